// File: rtl/servo_pwm_pkg.sv
// Shared op codes and width helpers for the servo PWM generator.
// Helpers work on a 33-bit scratch width, so any CNT_W up to 32 fits without wrap.
package servo_pwm_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam int WIDE_W = 33;

  typedef logic [WIDE_W-1:0] wide_t;

  function automatic wide_t clamp(
    input wide_t v,
    input wide_t lo,
    input wide_t hi
  );
    wide_t r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

  function automatic wide_t slew_step(
    input wide_t cur,
    input wide_t tgt,
    input wide_t slew
  );
    wide_t diff;
    wide_t r;
    diff = (tgt > cur) ? tgt - cur : cur - tgt;
    if (slew == '0 || diff <= slew) r = tgt;
    else if (tgt > cur) r = cur + slew;
    else r = cur - slew;
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: target/width registers, slew at phase wrap,
// registered pulse comparator and settled flag.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W     = 20,
  parameter int PERIOD    = 1_000_000,
  parameter int PULSE_MIN = 25_000,
  parameter int PULSE_MAX = 125_000,
  parameter int STEP      = 20_000,
  parameter int SLEW      = 5_000,
  parameter int OFFSET    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] data,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm,
  output logic             settled
);

  localparam wide_t W_MIN  = wide_t'(PULSE_MIN);
  localparam wide_t W_MAX  = wide_t'(PULSE_MAX);
  localparam wide_t W_STEP = wide_t'(STEP);
  localparam wide_t W_SLEW = wide_t'(SLEW);
  localparam wide_t W_PER  = wide_t'(PERIOD);
  localparam wide_t W_OFF  = wide_t'(OFFSET);

  localparam logic [CNT_W-1:0] RST_W = CNT_W'(PULSE_MIN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] target_nxt;
  logic [CNT_W-1:0] width_nxt;
  logic [CNT_W-1:0] phase;
  wide_t            ph_x;
  wide_t            tgt_x;
  logic             tick;

  always_comb begin
    ph_x  = wide_t'(cnt) + W_OFF;
    phase = (ph_x >= W_PER) ? CNT_W'(ph_x - W_PER)
                            : CNT_W'(ph_x);
  end

  assign tick = (phase == LAST);

  always_comb begin
    tgt_x = wide_t'(target);
    unique case (1'b1)
      sel && op == OP_UP:
        tgt_x = clamp(tgt_x + W_STEP, W_MIN, W_MAX);
      sel && op == OP_DOWN:
        tgt_x = (tgt_x < W_MIN + W_STEP) ? W_MIN
                                         : tgt_x - W_STEP;
      sel && op == OP_LOAD:
        tgt_x = clamp(wide_t'(data), W_MIN, W_MAX);
      default: ;
    endcase
    target_nxt = CNT_W'(tgt_x);
    // Width only moves at this channel's phase wrap, so a pulse never glitches
    width_nxt  = width;
    if (tick)
      width_nxt = CNT_W'(slew_step(wide_t'(width),
                                   wide_t'(target),
                                   W_SLEW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target  <= RST_W;
      width   <= RST_W;
      pwm     <= 1'b0;
      settled <= 1'b1;
    end else begin
      target  <= target_nxt;
      width   <= width_nxt;
      settled <= (width_nxt == target_nxt);
      pwm     <= en && (phase < width);
    end
  end

endmodule

// File: rtl/multi_servo_pwm.sv
// Multi-channel servo PWM: shared frame counter, command handshake and decode.
// Define MULTI_SERVO_STAGGER_EN to spread channel phases across the frame.
module multi_servo_pwm
  import servo_pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 20,
  parameter int PERIOD    = 1_000_000,
  parameter int PULSE_MIN = 25_000,
  parameter int PULSE_MAX = 125_000,
  parameter int STEP      = 20_000,
  parameter int SLEW      = 5_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [3:0]          cmd_ch,
  input  logic [CNT_W-1:0]    cmd_data,
  output logic [CHANNELS-1:0] pwm,
  output logic [CHANNELS-1:0] settled,
  output logic                frame_start,
  output logic                cmd_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             accept;
  logic             bad_ch;

  assign wrap      = (cnt == LAST);
  // Holding off commands on the wrap cycle keeps target and width edges apart
  assign cmd_ready = !wrap;
  assign accept    = cmd_valid && cmd_ready;
  assign bad_ch    = {1'b0, cmd_ch} >= 5'(CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cnt         <= wrap ? '0 : cnt + CNT_W'(1);
      frame_start <= wrap;
      cmd_err     <= accept && bad_ch;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef MULTI_SERVO_STAGGER_EN
    localparam int OFF = i * (PERIOD / CHANNELS);
`else
    localparam int OFF = 0;
`endif
    servo_pwm_channel #(
      .CNT_W    (CNT_W),
      .PERIOD   (PERIOD),
      .PULSE_MIN(PULSE_MIN),
      .PULSE_MAX(PULSE_MAX),
      .STEP     (STEP),
      .SLEW     (SLEW),
      .OFFSET   (OFF)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (enable[i]),
      .sel    (accept && cmd_ch == 4'(i)),
      .op     (cmd_op),
      .data   (cmd_data),
      .cnt    (cnt),
      .pwm    (pwm[i]),
      .settled(settled[i])
    );
  end

endmodule
